// File: rtl/shift_unit_ctrl_if.sv
// shift_unit_ctrl_if: issue and retire handshake bundle of the shift unit
interface shift_unit_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAGW-1:0]  out_tag;
  logic             out_err;
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err
  );
endinterface

// File: rtl/shift_unit_ctrl.sv
// shift_unit_ctrl: issue/retire control around a pipelined arithmetic barrel shifter
module shift_unit_ctrl #(
  parameter int WIDTH     = 32,
  parameter int WIDTHDIST = 5,
  parameter int PIPELINE  = 2,
  parameter int TAGW      = 4
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 flush,
  shift_unit_ctrl_if.slave     io,
  output logic                 sh_aclr,
  output logic                 sh_clken,
  output logic [WIDTH-1:0]     sh_data,
  output logic [WIDTHDIST-1:0] sh_distance,
  output logic                 sh_direction,
  input  logic [WIDTH-1:0]     sh_result
);
  localparam int EW = WIDTH + TAGW + 1;
  if (PIPELINE < 1) begin : g_bad_pipeline
    $error("shift_unit_ctrl: PIPELINE must be at least 1");
  end
  logic [PIPELINE-1:0]                 v_q, v_d;
  logic [PIPELINE-1:0][1:0]            op_q, op_d;
  logic [PIPELINE-1:0][WIDTHDIST-1:0]  dist_q, dist_d;
  logic [PIPELINE-1:0][TAGW-1:0]       tag_q, tag_d;
  logic [1:0][EW-1:0]                  mem_q, mem_d;
  logic [1:0]                          count_q, count_d;
  logic                                out_valid_q, out_valid_d;
  logic [EW-1:0]                       out_q, out_d;
  logic                                v_last, pop, push, fifo_space;
  logic [1:0]                          op_last, left;
  logic [WIDTHDIST-1:0]                dist_last;
  logic [TAGW-1:0]                     tag_last;
  logic [WIDTH-1:0]                    fixed;
  assign v_last       = v_q[PIPELINE-1];
  assign op_last      = op_q[PIPELINE-1];
  assign dist_last    = dist_q[PIPELINE-1];
  assign tag_last     = tag_q[PIPELINE-1];
  assign pop          = out_valid_q & io.out_ready;
  assign fifo_space   = (count_q < 2'd2) | pop;
  assign sh_clken     = ~v_last | fifo_space;
  assign push         = sh_clken & v_last;
  assign io.in_ready  = sh_clken & ~flush & aclr_n;
  assign sh_aclr      = ~aclr_n;
  assign sh_data      = io.in_a;
  assign sh_direction = io.in_op != 2'b00;
  assign sh_distance  = io.in_op == 2'b11 ? '0 : io.in_b[WIDTHDIST-1:0];
  // the shifter only does arithmetic right shifts, so SRL clears the sign-filled top bits
  assign fixed        = op_last == 2'b01 ? sh_result & ({WIDTH{1'b1}} >> dist_last) : sh_result;
  assign io.out_valid = out_valid_q;
  assign {io.out_result, io.out_tag, io.out_err} = out_q;
  // sideband pipe moves in lockstep with the shifter; non-handshake cycles enter as bubbles
  always_comb begin
    v_d    = v_q;
    op_d   = op_q;
    dist_d = dist_q;
    tag_d  = tag_q;
    if (sh_clken) begin
      v_d[0]    = io.in_valid & io.in_ready;
      op_d[0]   = io.in_op;
      dist_d[0] = sh_distance;
      tag_d[0]  = io.in_tag;
      for (int i = 1; i < PIPELINE; i++) begin
        v_d[i]    = v_q[i-1];
        op_d[i]   = op_q[i-1];
        dist_d[i] = dist_q[i-1];
        tag_d[i]  = tag_q[i-1];
      end
    end
    if (flush) v_d = '0;
  end
  // 2-entry fifo: pop then push; the output regs only present entries held before this edge
  always_comb begin
    left        = count_q - {1'b0, pop};
    mem_d       = mem_q;
    if (pop) mem_d[0] = mem_q[1];
    if (push) mem_d[left[0]] = {fixed, tag_last, op_last == 2'b11};
    count_d     = flush ? 2'd0 : left + {1'b0, push};
    out_valid_d = ~flush & (left != 2'd0);
    out_d       = out_valid_d ? (pop ? mem_q[1] : mem_q[0]) : '0;
  end
  // state registers, cleared asynchronously so outputs drop as soon as reset asserts
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      v_q         <= '0;
      op_q        <= '0;
      dist_q      <= '0;
      tag_q       <= '0;
      mem_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      v_q         <= v_d;
      op_q        <= op_d;
      dist_q      <= dist_d;
      tag_q       <= tag_d;
      mem_q       <= mem_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end
endmodule

// File: tb/tb_shift_unit_ctrl.sv
// tb_shift_unit_ctrl: randomized and directed checks of the shift unit controller
module tb_shift_unit_ctrl;
  localparam int W = 32;
  localparam int D = 5;
  localparam int P = 2;
  localparam int T = 4;
  typedef struct packed {logic [W-1:0] r; logic [T-1:0] t; logic e;} ent_t;
  logic clock = 1'b0;
  logic aclr_n = 1'b0;
  logic flush = 1'b0;
  logic sh_aclr, sh_clken, sh_direction;
  logic [W-1:0] sh_data, sh_result;
  logic [D-1:0] sh_distance;
  int total = 0, bad = 0, cyc = 0, acc = 0, unexp = 0;
  ent_t exp_q[$], got_q[$], ref_q[$];
  int expc_q[$], gotc_q[$], refc_q[$];
  shift_unit_ctrl_if #(.WIDTH(W), .TAGW(T)) io ();
  shift_unit_ctrl #(.WIDTH(W), .WIDTHDIST(D), .PIPELINE(P), .TAGW(T)) dut (
    .clock(clock), .aclr_n(aclr_n), .flush(flush), .io(io.slave),
    .sh_aclr(sh_aclr), .sh_clken(sh_clken), .sh_data(sh_data),
    .sh_distance(sh_distance), .sh_direction(sh_direction), .sh_result(sh_result)
  );
  always #5 clock = ~clock;
  // external shifter: TYPE=ARITHMETIC, PIPELINE=P, clken and aclr qualified
  logic [W-1:0] sp [P];
  logic signed [W-1:0] sh_sra;
  assign sh_sra = $signed(sh_data) >>> sh_distance;
  always @(posedge clock or posedge sh_aclr) begin
    if (sh_aclr) begin
      for (int i = 0; i < P; i++) sp[i] <= '0;
    end else if (sh_clken) begin
      sp[0] <= sh_direction ? sh_sra : sh_data << sh_distance;
      for (int i = 1; i < P; i++) sp[i] <= sp[i-1];
    end
  end
  assign sh_result = sp[P-1];
  function automatic ent_t model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [T-1:0] t);
    ent_t m;
    int d;
    logic signed [W-1:0] s;
    d = int'(b[D-1:0]);
    s = $signed(a) >>> d;
    m.t = t;
    m.e = (op == 2'b11);
    m.r = op == 2'b00 ? a << d : op == 2'b01 ? a >> d : op == 2'b10 ? s : a;
    return m;
  endfunction
  task automatic tick();
    logic hs_in, hs_out;
    ent_t o, e;
    #1;
    hs_in = io.in_valid & io.in_ready;
    hs_out = io.out_valid & io.out_ready;
    o = {io.out_result, io.out_tag, io.out_err};
    e = model(io.in_op, io.in_a, io.in_b, io.in_tag);
    @(posedge clock);
    cyc++;
    if (hs_out) begin
      if (exp_q.size() == 0) unexp++;
      else begin
        got_q.push_back(o);
        gotc_q.push_back(cyc);
        ref_q.push_back(exp_q.pop_front());
        refc_q.push_back(expc_q.pop_front());
      end
    end
    if (flush || !aclr_n) begin
      exp_q.delete();
      expc_q.delete();
    end
    if (hs_in) begin
      exp_q.push_back(e);
      expc_q.push_back(cyc);
      acc++;
    end
    @(negedge clock);
  endtask
  task automatic clear_sb();
    got_q.delete(); gotc_q.delete(); ref_q.delete(); refc_q.delete();
  endtask
  task automatic drain(int n);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    repeat (n) tick();
  endtask
  task automatic issue(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [T-1:0] t);
    int a0;
    a0 = acc;
    io.in_valid = 1'b1; io.in_op = op; io.in_a = a; io.in_b = b; io.in_tag = t;
    for (int i = 0; i < 50 && acc == a0; i++) tick();
    io.in_valid = 1'b0;
    total++;
    if (acc == a0) begin
      bad++;
      $display("FAIL issue_timeout: accepted=0 required=1 (tag %0d)", t);
    end
  endtask
  task automatic test_reset();
    aclr_n = 1'b0; flush = 1'b0;
    io.in_valid = 1'b0; io.in_op = '0; io.in_a = '0; io.in_b = '0; io.in_tag = '0; io.out_ready = 1'b0;
    @(negedge clock); #1;
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
    total++; if (io.out_result !== '0) begin bad++; $display("FAIL reset_out_result: got %h want 0", io.out_result); end
    total++; if ({io.out_tag, io.out_err} !== '0) begin bad++; $display("FAIL reset_tag_err: got %h want 0", {io.out_tag, io.out_err}); end
    total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", io.in_ready); end
    total++; if (sh_aclr !== 1'b1) begin bad++; $display("FAIL reset_sh_aclr: got %b want 1", sh_aclr); end
    @(negedge clock);
    aclr_n = 1'b1;
    #1;
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", io.in_ready); end
    @(negedge clock);
  endtask
  task automatic test_sll();
    clear_sb();
    io.out_ready = 1'b1;
    issue(2'b00, 32'h0000_0001, 32'd31, 4'd5);
    drain(8);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL sll_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0].r !== 32'h8000_0000) begin bad++; $display("FAIL sll_result: got %h want 80000000", got_q[0].r); end
      total++; if (got_q[0].t !== 4'd5 || got_q[0].e !== 1'b0) begin bad++; $display("FAIL sll_tag_err: got %h/%b want 5/0", got_q[0].t, got_q[0].e); end
      // visible after edge k+P+1, so the consumer takes it at edge k+P+2
      total++; if (gotc_q[0] - refc_q[0] != P + 2) begin bad++; $display("FAIL sll_latency: got %0d want %0d", gotc_q[0] - refc_q[0], P + 2); end
    end
  endtask
  task automatic test_srl_sra();
    logic [W-1:0] er [3];
    er[0] = 32'h0F00_0000; er[1] = 32'hFF00_0000; er[2] = 32'hF000_0000;
    clear_sb();
    io.out_ready = 1'b1;
    issue(2'b01, 32'hF000_0000, 32'd4, 4'd1);
    issue(2'b10, 32'hF000_0000, 32'd4, 4'd2);
    issue(2'b01, 32'hF000_0000, 32'd0, 4'd3);
    drain(10);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL shr_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++; if (got_q[i].r !== er[i]) begin bad++; $display("FAIL shr_result%0d: got %h want %h", i, got_q[i].r, er[i]); end
      total++; if (got_q[i].t !== 4'(i + 1)) begin bad++; $display("FAIL shr_tag%0d: got %0d want %0d", i, got_q[i].t, i + 1); end
      total++; if (gotc_q[i] - gotc_q[0] != i) begin bad++; $display("FAIL shr_throughput%0d: got %0d want %0d", i, gotc_q[i] - gotc_q[0], i); end
    end
  endtask
  task automatic test_illegal();
    clear_sb();
    issue(2'b11, 32'h1234_5678, 32'd7, 4'd9);
    drain(8);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL ill_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0].r !== 32'h1234_5678) begin bad++; $display("FAIL ill_result: got %h want 12345678", got_q[0].r); end
      total++; if (got_q[0].e !== 1'b1 || got_q[0].t !== 4'd9) begin bad++; $display("FAIL ill_err_tag: got %b/%h want 1/9", got_q[0].e, got_q[0].t); end
    end
  endtask
  task automatic test_back_to_back();
    int a0, n;
    clear_sb();
    a0 = acc; n = 0;
    io.out_ready = 1'b0;
    io.in_valid = 1'b1; io.in_op = 2'($urandom_range(0, 2)); io.in_a = $urandom; io.in_b = $urandom; io.in_tag = 4'd0;
    repeat (12) begin
      tick();
      if (acc - a0 != n) begin
        n = acc - a0;
        io.in_op = 2'($urandom_range(0, 2)); io.in_a = $urandom; io.in_b = $urandom; io.in_tag = 4'(n);
      end
    end
    #1;
    total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready: got %b want 0", io.in_ready); end
    total++; if (acc - a0 != 4) begin bad++; $display("FAIL b2b_held: got %0d want 4", acc - a0); end
    total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid: got %b want 1", io.out_valid); end
    io.out_ready = 1'b1;
    for (int i = 0; i < 60 && n < 8; i++) begin
      tick();
      if (acc - a0 != n) begin
        n = acc - a0;
        io.in_op = 2'($urandom_range(0, 2)); io.in_a = $urandom; io.in_b = $urandom; io.in_tag = 4'(n);
      end
    end
    drain(12);
    total++; if (got_q.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== ref_q[i] || got_q[i].t !== 4'(i)) begin bad++; $display("FAIL b2b_entry%0d: got %h want %h tag %0d", i, got_q[i], ref_q[i], i); end
    end
  endtask
  task automatic test_flush();
    int u0;
    clear_sb();
    u0 = unexp;
    io.out_ready = 1'b0;
    issue(2'b00, 32'h0000_00FF, 32'd4, 4'd1);
    repeat (4) tick();
    total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL flush_setup: got %b want 1", io.out_valid); end
    issue(2'b00, 32'h0000_0001, 32'd1, 4'd2);
    issue(2'b10, 32'h8000_0000, 32'd3, 4'd3);
    flush = 1'b1; io.out_ready = 1'b1;
    tick();
    flush = 1'b0; io.out_ready = 1'b0;
    #1;
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", io.out_valid); end
    drain(10);
    total++; if (got_q.size() != 1 || unexp != u0) begin bad++; $display("FAIL flush_stale: got %0d results %0d unexpected want 1 0", got_q.size(), unexp - u0); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0].r !== 32'h0000_0FF0 || got_q[0].t !== 4'd1) begin bad++; $display("FAIL flush_pop: got %h/%h want 00000ff0/1", got_q[0].r, got_q[0].t); end
    end
    clear_sb();
    issue(2'b00, 32'h0000_0003, 32'd2, 4'd7);
    drain(8);
    total++; if (got_q.size() != 1 || got_q[0].r !== 32'h0000_000C || got_q[0].t !== 4'd7) begin bad++; $display("FAIL flush_fresh: got %0d results first %h want 1 0000000c/7", got_q.size(), got_q.size() > 0 ? got_q[0] : '0); end
  endtask
  task automatic test_reset_mid();
    clear_sb();
    io.out_ready = 1'b0;
    issue(2'b00, 32'h1, 32'd1, 4'd1);
    issue(2'b01, 32'h10, 32'd1, 4'd2);
    issue(2'b10, 32'h100, 32'd1, 4'd3);
    tick();
    aclr_n = 1'b0;
    #1;
    total++; if (io.out_valid !== 1'b0 || io.out_result !== '0) begin bad++; $display("FAIL rst_mid_out: got %b/%h want 0/0", io.out_valid, io.out_result); end
    total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 0", io.in_ready); end
    @(negedge clock);
    tick();
    aclr_n = 1'b1;
    io.out_ready = 1'b1;
    issue(2'b10, 32'h8000_0000, 32'd31, 4'hA);
    drain(8);
    total++; if (got_q.size() != 1 || got_q[0].r !== 32'hFFFF_FFFF || got_q[0].t !== 4'hA) begin bad++; $display("FAIL rst_mid_fresh: got %0d results first %h want 1 ffffffff/a", got_q.size(), got_q.size() > 0 ? got_q[0] : '0); end
  endtask
  task automatic test_random();
    int a0, u0;
    clear_sb();
    a0 = acc; u0 = unexp;
    repeat (300) begin
      io.in_valid = ($urandom % 4) != 0;
      io.in_op = 2'($urandom); io.in_a = $urandom; io.in_b = $urandom; io.in_tag = 4'($urandom);
      io.out_ready = ($urandom % 3) != 0;
      tick();
    end
    drain(20);
    total++; if (got_q.size() != acc - a0 || unexp != u0) begin bad++; $display("FAIL rand_count: got %0d results %0d unexpected want %0d 0", got_q.size(), unexp - u0, acc - a0); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== ref_q[i]) begin bad++; $display("FAIL rand_entry%0d: got %h want %h", i, got_q[i], ref_q[i]); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_sll();
    test_srl_sra();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
